// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare codes plus an
// iterative shift-add multiply that stalls the pipeline through busy_o.
module alu_exec_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSltu = 4'b0011;
  localparam logic [3:0] CtrlSlt  = 4'b0100;
  localparam logic [3:0] CtrlMul  = 4'b0101;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlBeq  = 4'b0111;
  localparam logic [3:0] CtrlSra  = 4'b1000;
  localparam logic [3:0] CtrlSrav = 4'b1001;
  localparam logic [3:0] CtrlLui  = 4'b1011;
  localparam logic [3:0] CtrlSgt  = 4'b1100;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;

  // Single-cycle result; unassigned codes (including mul) fall to zero here.
  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      CtrlAnd:  alu_res = src1_i & src2_i;
      CtrlOr:   alu_res = src1_i | src2_i;
      CtrlAdd:  alu_res = src1_i + src2_i;
      CtrlSltu: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      CtrlSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      CtrlSub,
      CtrlBeq:  alu_res = src1_i - src2_i;
      CtrlSra:  alu_res = WIDTH'($signed(src2_i) >>> shamt_i);
      CtrlSrav: alu_res = WIDTH'($signed(src2_i) >>> src1_i[4:0]);
      CtrlLui:  alu_res = src2_i << 16;
      CtrlSgt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) > $signed(src2_i))};
      default:  alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (ctrl_i == CtrlMul) begin
            state_d  = StMul;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        // Last iteration publishes the sum including this cycle's partial product.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StIdle;
          cnt_d    = '0;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q == StMul);

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: per-cycle model compare plus literal spot checks.
module tb_alu_exec_seq;
  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [3:0]    ctrl_i;
  logic [W-1:0]  src1_i;
  logic [W-1:0]  src2_i;
  logic [4:0]    shamt_i;
  logic [W-1:0]  result_o;
  logic          zero_o;
  logic          done_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .ctrl_i  (ctrl_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .shamt_i (shamt_i),
    .result_o(result_o),
    .zero_o  (zero_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return (a < b) ? 1 : 0;
      4'd4:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd5:  return a * b;
      4'd6,
      4'd7:  return a - b;
      4'd8:  return $signed(b) >>> sh;
      4'd9:  return $signed(b) >>> a[4:0];
      4'd11: return b << 16;
      4'd12: return ($signed(a) > $signed(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Behavioural model: a multiply is just "product appears W cycles later".
  logic [W-1:0] m_res, m_prod;
  logic         m_zero, m_done, m_busy, m_valid = 1'b0;
  int           m_left;
  int           cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_res = 0; m_zero = 1; m_done = 0; m_busy = 0; m_left = 0; m_valid = 1;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; m_res = m_prod; m_zero = (m_prod == 0); m_done = 1;
        end
      end else if (start_i) begin
        if (ctrl_i == 4'd5) begin
          m_busy = 1; m_left = W; m_prod = src1_i * src2_i;
        end else begin
          m_res = ref_alu(ctrl_i, src1_i, src2_i, shamt_i);
          m_zero = (m_res == 0); m_done = 1;
        end
      end
    end
  end

  // Literal spot-check request, serviced by the single compare process.
  logic         lit_en = 1'b0;
  int           lit_kind;
  logic [W-1:0] lit_val;
  string        lit_name;
  logic         got_done;
  int           lat;

  int n_cmp = 0;
  int n_fail = 0;

  always @(negedge clk_i) begin
    logic [W-1:0] act;
    if (m_valid) begin
      n_cmp += 4;
      if (result_o !== m_res) begin
        n_fail++; $display("FAIL model_result t=%0t: got %h expected %h", $time, result_o, m_res);
      end
      if (zero_o !== m_zero) begin
        n_fail++; $display("FAIL model_zero t=%0t: got %b expected %b", $time, zero_o, m_zero);
      end
      if (done_o !== m_done) begin
        n_fail++; $display("FAIL model_done t=%0t: got %b expected %b", $time, done_o, m_done);
      end
      if (busy_o !== m_busy) begin
        n_fail++; $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy_o, m_busy);
      end
    end
    if (lit_en) begin
      case (lit_kind)
        0:       act = result_o;
        1:       act = {{(W-1){1'b0}}, zero_o};
        2:       act = {{(W-1){1'b0}}, busy_o};
        3:       act = {{(W-1){1'b0}}, got_done};
        default: act = W'(lat);
      endcase
      n_cmp++;
      if (act !== lit_val) begin
        n_fail++; $display("FAIL %s: got %h expected %h", lit_name, act, lit_val);
      end
    end
  end

  task automatic chk(input string name, input int kind, input logic [W-1:0] val);
    lit_name = name; lit_kind = kind; lit_val = val; lit_en = 1'b1;
    @(negedge clk_i);
    #1 lit_en = 1'b0;
  endtask

  // Drive one request at the negedge; returns just after the accepting edge.
  task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [4:0] sh);
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int e_cyc);
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    lat = cyc - e_cyc;
  endtask

  initial begin
    int e;
    rst_i = 1'b0; start_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0; shamt_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("reset_result", 0, 32'h0);
    chk("reset_zero", 1, 32'h1);
    chk("reset_busy", 2, 32'h0);

    op(4'b0010, 32'd5, 32'd7, 5'd0);           chk("add_5_7", 0, 32'd12);
    op(4'b0111, 32'h1234, 32'h1234, 5'd0);     chk("beq_zero", 1, 32'h1);
    op(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0);   chk("sltu", 0, 32'h0);
    op(4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd0);   chk("slt", 0, 32'h1);
    op(4'b1000, 32'h0, 32'h8000_0000, 5'd4);   chk("sra_shamt", 0, 32'hF800_0000);
    op(4'b1011, 32'h0, 32'h0000_ABCD, 5'd0);   chk("lui16", 0, 32'hABCD_0000);
    op(4'b1001, 32'd8, 32'h8000_0000, 5'd1);   chk("srav", 0, 32'hFF80_0000);
    op(4'b1100, 32'd5, 32'hFFFF_FFFD, 5'd0);   chk("sgt", 0, 32'h1);
    op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0); chk("and", 0, 32'h00F0_1234);
    op(4'b0001, 32'hF000_0001, 32'h0000_0F00, 5'd0); chk("or", 0, 32'hF000_0F01);
    op(4'b0110, 32'd3, 32'd5, 5'd0);           chk("sub_neg", 0, 32'hFFFF_FFFE);
    op(4'b1010, 32'd3, 32'd5, 5'd0);           chk("undef_zero", 1, 32'h1);

    // Multiply with a stray start in the middle.
    op(4'b0101, 32'd7, 32'd6, 5'd0);
    e = cyc;
    repeat (4) @(posedge clk_i);
    op(4'b0010, 32'd100, 32'd100, 5'd0);
    src1_i = 32'd9; src2_i = 32'd9;
    wait_done(e);
    chk("mul_done_seen", 3, 32'h1);
    chk("mul_latency", 4, 32'd32);
    chk("mul_7_6", 0, 32'd42);
    repeat (3) @(posedge clk_i);
    chk("mul_held", 0, 32'd42);

    // Overflowing multiply, then an add issued in the done cycle.
    op(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    e = cyc;
    wait_done(e);
    op(4'b0010, 32'd3, 32'd4, 5'd0);
    chk("b2b_add", 0, 32'd7);
    chk("ovf_done_seen", 3, 32'h1);

    // Reset in the middle of a multiply.
    op(4'b0101, 32'd7, 32'd6, 5'd0);
    repeat (9) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("abort_busy", 2, 32'h0);
    chk("abort_result", 0, 32'h0);
    repeat (40) @(posedge clk_i);
    op(4'b0010, 32'd1, 32'd1, 5'd0);
    chk("post_reset_add", 0, 32'd2);

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
